// File: rtl/fetch_align_ctrl_if.sv
// Fetch-side bus bundle for fetch_align_ctrl: memory request/response, decode-side
// instruction handoff and execute redirect. The controller uses the master modport.
interface fetch_align_ctrl_if;
    localparam int unsigned XLEN = 32;

    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic            fetch_req;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_ack;
    logic            inst_valid;
    logic [XLEN-1:0] inst_in;
    logic            inst_out_valid;
    logic            inst_out_ready;
    logic [XLEN-1:0] inst_out;
    logic [XLEN-1:0] inst_pc_out;
    logic            inst_is_compressed;
    logic            misalign_fetch;

    modport master (
        input  flush, redirect_pc, fetch_ack, inst_valid, inst_in, inst_out_ready,
        output fetch_req, fetch_pc, inst_out_valid, inst_out, inst_pc_out,
               inst_is_compressed, misalign_fetch
    );

    modport slave (
        output flush, redirect_pc, fetch_ack, inst_valid, inst_in, inst_out_ready,
        input  fetch_req, fetch_pc, inst_out_valid, inst_out, inst_pc_out,
               inst_is_compressed, misalign_fetch
    );
endinterface

// File: rtl/fetch_align_ctrl.sv
// RV32IC fetch sequencer: word-aligned requests, halfword PC, compressed split and
// straddle stitching. Compressed support is enabled by defining FETCH_RVC_EN.
module fetch_align_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    fetch_align_ctrl_if.master  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned HLEN = 16;

`ifdef FETCH_RVC_EN
    localparam bit RVC_EN = 1'b1;
`else
    localparam bit RVC_EN = 1'b0;
`endif

    // Without RVC the PC stays word aligned, so bit 1 is forced low everywhere
    localparam logic [XLEN-1:1] RESET_PC_HW = {RESET_PC[XLEN-1:2], RVC_EN & RESET_PC[1]};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_DROP
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:1]   pc_q, pc_d;
    logic [XLEN-1:0]   wbuf, wbuf_d;
    logic [HLEN-1:0]   hw_buf, hw_buf_d;
    logic              hw_valid, hw_valid_d;

    logic              req;
    logic [XLEN-1:0]   req_pc;
    logic              misalign;
    logic              out_valid;
    logic [XLEN-1:0]   out_inst;
    logic [XLEN-1:0]   out_pc;
    logic              out_rvc;
    logic              consume;
    logic              stay_drain;
    logic              outstanding;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC_HW;
            wbuf     <= '0;
            hw_buf   <= '0;
            hw_valid <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            wbuf     <= wbuf_d;
            hw_buf   <= hw_buf_d;
            hw_valid <= hw_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        wbuf_d      = wbuf;
        hw_buf_d    = hw_buf;
        hw_valid_d  = hw_valid;
        req         = 1'b0;
        req_pc      = '0;
        misalign    = 1'b0;
        out_valid   = 1'b0;
        out_inst    = '0;
        out_pc      = '0;
        out_rvc     = 1'b0;
        consume     = 1'b0;
        stay_drain  = 1'b0;
        outstanding = 1'b0;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;

            // A pending upper half means the request targets the following word
            ST_REQ: begin
                req      = 1'b1;
                misalign = hw_valid;
                req_pc   = hw_valid ? {pc_q[XLEN-1:2] + 30'd1, 2'b00}
                                    : {pc_q[XLEN-1:2], 2'b00};
                if (bus.fetch_ack) state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (bus.inst_valid) begin
                    wbuf_d  = bus.inst_in;
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                out_pc = {pc_q, 1'b0};
                if (RVC_EN && hw_valid) begin
                    out_valid = 1'b1;
                    out_inst  = {wbuf[HLEN-1:0], hw_buf};
                end else if (!RVC_EN) begin
                    out_valid = 1'b1;
                    out_inst  = wbuf;
                end else if (!pc_q[1]) begin
                    out_valid = 1'b1;
                    if (wbuf[1:0] == 2'b11) begin
                        out_inst = wbuf;
                    end else begin
                        out_inst = {16'h0000, wbuf[HLEN-1:0]};
                        out_rvc  = 1'b1;
                    end
                end else if (wbuf[17:16] != 2'b11) begin
                    out_valid = 1'b1;
                    out_inst  = {16'h0000, wbuf[XLEN-1:HLEN]};
                    out_rvc   = 1'b1;
                end

                // Stitched or low-half compressed leaves more of this word to drain
                consume    = out_valid && bus.inst_out_ready && !bus.flush;
                stay_drain = (RVC_EN && hw_valid) || (out_rvc && !pc_q[1]);
                if (consume) begin
                    pc_d       = pc_q + (out_rvc ? 31'd1 : 31'd2);
                    hw_valid_d = 1'b0;
                    state_d    = stay_drain ? ST_DRAIN : ST_REQ;
                end else if (!out_valid) begin
                    hw_buf_d   = wbuf[XLEN-1:HLEN];
                    hw_valid_d = 1'b1;
                    state_d    = ST_REQ;
                end
            end

            ST_DROP: begin
                if (bus.inst_valid) state_d = ST_REQ;
            end

            default: state_d = ST_IDLE;
        endcase

        // Redirect overrides everything; an in-flight response must be swallowed
        if (bus.flush && (state_q != ST_IDLE)) begin
            pc_d        = {bus.redirect_pc[XLEN-1:2], RVC_EN & bus.redirect_pc[1]};
            hw_valid_d  = 1'b0;
            outstanding = ((state_q == ST_WAIT) && !bus.inst_valid) ||
                          ((state_q == ST_REQ)  &&  bus.fetch_ack)  ||
                          ((state_q == ST_DROP) && !bus.inst_valid);
            state_d     = outstanding ? ST_DROP : ST_REQ;
        end

        if (!RVC_EN) begin
            hw_valid_d = 1'b0;
            pc_d[1]    = 1'b0;
        end
    end

    assign bus.fetch_req          = req;
    assign bus.fetch_pc           = req_pc;
    assign bus.misalign_fetch     = misalign;
    assign bus.inst_out_valid     = out_valid;
    assign bus.inst_out           = out_valid ? out_inst : '0;
    assign bus.inst_pc_out        = out_valid ? out_pc : '0;
    assign bus.inst_is_compressed = out_valid & out_rvc;

endmodule

// File: tb/tb_fetch_align_ctrl.sv
// Directed bench for fetch_align_ctrl; expectations follow the active FETCH_RVC_EN setting.
module tb_fetch_align_ctrl;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    fetch_align_ctrl_if bus();

    fetch_align_ctrl #(.RESET_PC(32'h0000_0100)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assumes the DUT is in REQ; leaves it in DRAIN holding w
    task automatic fetch_word(input logic [31:0] w);
        bus.fetch_ack = 1'b1;
        tick();
        bus.fetch_ack = 1'b0;
        check_eq("wait_no_req", 32'(bus.fetch_req), 32'd0);
        bus.inst_valid = 1'b1;
        bus.inst_in    = w;
        tick();
        bus.inst_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        bus.flush          = 1'b0;
        bus.redirect_pc    = '0;
        bus.fetch_ack      = 1'b0;
        bus.inst_valid     = 1'b0;
        bus.inst_in        = '0;
        bus.inst_out_ready = 1'b1;
        #2 reset = 1'b0;
        repeat (2) tick();

        check_eq("rst_fetch_req", 32'(bus.fetch_req), 32'd0);
        check_eq("rst_fetch_pc", bus.fetch_pc, 32'd0);
        check_eq("rst_out_valid", 32'(bus.inst_out_valid), 32'd0);
        check_eq("rst_inst_out", bus.inst_out, 32'd0);
        check_eq("rst_inst_pc", bus.inst_pc_out, 32'd0);
        check_eq("rst_misalign", 32'(bus.misalign_fetch), 32'd0);
        check_eq("rst_compressed", 32'(bus.inst_is_compressed), 32'd0);

        reset = 1'b1;
        tick();
        check_eq("boot_req", 32'(bus.fetch_req), 32'd1);
        check_eq("boot_pc", bus.fetch_pc, 32'h0000_0100);

        fetch_word(32'h4501_4581);
`ifdef FETCH_RVC_EN
        check_eq("c0_valid", 32'(bus.inst_out_valid), 32'd1);
        check_eq("c0_inst", bus.inst_out, 32'h0000_4581);
        check_eq("c0_pc", bus.inst_pc_out, 32'h0000_0100);
        check_eq("c0_rvc", 32'(bus.inst_is_compressed), 32'd1);
        tick();
        check_eq("c1_inst", bus.inst_out, 32'h0000_4501);
        check_eq("c1_pc", bus.inst_pc_out, 32'h0000_0102);
        check_eq("c1_rvc", 32'(bus.inst_is_compressed), 32'd1);
        tick();
`else
        check_eq("w0_valid", 32'(bus.inst_out_valid), 32'd1);
        check_eq("w0_inst", bus.inst_out, 32'h4501_4581);
        check_eq("w0_pc", bus.inst_pc_out, 32'h0000_0100);
        check_eq("w0_rvc", 32'(bus.inst_is_compressed), 32'd0);
        tick();
`endif
        check_eq("next_req", 32'(bus.fetch_req), 32'd1);
        check_eq("next_pc", bus.fetch_pc, 32'h0000_0104);
        check_eq("next_no_out", 32'(bus.inst_out_valid), 32'd0);

        // Fetch buffer back-pressure
        bus.inst_out_ready = 1'b0;
        fetch_word(32'h0000_0013);
        for (int i = 0; i < 5; i++) begin
            check_eq("stall_valid", 32'(bus.inst_out_valid), 32'd1);
            check_eq("stall_inst", bus.inst_out, 32'h0000_0013);
            check_eq("stall_pc", bus.inst_pc_out, 32'h0000_0104);
            check_eq("stall_no_req", 32'(bus.fetch_req), 32'd0);
            tick();
        end
        check_eq("stall_end_pc", bus.inst_pc_out, 32'h0000_0104);
        bus.inst_out_ready = 1'b1;
        tick();
        check_eq("post_stall_req", 32'(bus.fetch_req), 32'd1);
        check_eq("post_stall_pc", bus.fetch_pc, 32'h0000_0108);

        // Flush coinciding with ack: the old response must be dropped
        bus.fetch_ack   = 1'b1;
        bus.flush       = 1'b1;
        bus.redirect_pc = 32'h0000_0400;
        tick();
        bus.fetch_ack = 1'b0;
        bus.flush     = 1'b0;
        check_eq("drop_no_req", 32'(bus.fetch_req), 32'd0);
        check_eq("drop_no_out", 32'(bus.inst_out_valid), 32'd0);
        bus.inst_valid = 1'b1;
        bus.inst_in    = 32'h0000_0013;
        tick();
        bus.inst_valid = 1'b0;
        check_eq("drop_discard", 32'(bus.inst_out_valid), 32'd0);
        check_eq("redir_req", 32'(bus.fetch_req), 32'd1);
        check_eq("redir_pc", bus.fetch_pc, 32'h0000_0400);

        // Response strobe while in REQ is ignored
        bus.inst_valid = 1'b1;
        bus.inst_in    = 32'hdead_beef;
        tick();
        bus.inst_valid = 1'b0;
        check_eq("ign_req", 32'(bus.fetch_req), 32'd1);
        check_eq("ign_pc", bus.fetch_pc, 32'h0000_0400);
        check_eq("ign_no_out", 32'(bus.inst_out_valid), 32'd0);

        // Redirect to a halfword address
        bus.flush       = 1'b1;
        bus.redirect_pc = 32'h0000_0106;
        tick();
        bus.flush = 1'b0;
        check_eq("hw_redir_pc", bus.fetch_pc, 32'h0000_0104);
        fetch_word(32'h0000_4581);
`ifdef FETCH_RVC_EN
        check_eq("hw_inst", bus.inst_out, 32'h0000_0000);
        check_eq("hw_pc", bus.inst_pc_out, 32'h0000_0106);
        check_eq("hw_rvc", 32'(bus.inst_is_compressed), 32'd1);
`else
        check_eq("hw_inst", bus.inst_out, 32'h0000_4581);
        check_eq("hw_pc", bus.inst_pc_out, 32'h0000_0104);
        check_eq("hw_rvc", 32'(bus.inst_is_compressed), 32'd0);
`endif
        tick();
        check_eq("hw_next_pc", bus.fetch_pc, 32'h0000_0108);

        // Flush in WAIT with the response in the same cycle: straight back to REQ
        bus.fetch_ack = 1'b1;
        tick();
        bus.fetch_ack   = 1'b0;
        bus.flush       = 1'b1;
        bus.redirect_pc = 32'h0000_0500;
        bus.inst_valid  = 1'b1;
        bus.inst_in     = 32'h0000_0013;
        tick();
        bus.flush      = 1'b0;
        bus.inst_valid = 1'b0;
        check_eq("wflush_req", 32'(bus.fetch_req), 32'd1);
        check_eq("wflush_pc", bus.fetch_pc, 32'h0000_0500);
        check_eq("wflush_no_out", 32'(bus.inst_out_valid), 32'd0);

`ifdef FETCH_RVC_EN
        // Straddling 32-bit instruction at 0x202
        bus.flush       = 1'b1;
        bus.redirect_pc = 32'h0000_0202;
        tick();
        bus.flush = 1'b0;
        check_eq("st_pc0", bus.fetch_pc, 32'h0000_0200);
        check_eq("st_mis0", 32'(bus.misalign_fetch), 32'd0);
        fetch_word(32'h0093_4581);
        check_eq("st_no_out", 32'(bus.inst_out_valid), 32'd0);
        tick();
        check_eq("st_mis1", 32'(bus.misalign_fetch), 32'd1);
        check_eq("st_pc1", bus.fetch_pc, 32'h0000_0204);
        fetch_word(32'h4581_0513);
        check_eq("st_inst", bus.inst_out, 32'h0513_0093);
        check_eq("st_ipc", bus.inst_pc_out, 32'h0000_0202);
        check_eq("st_rvc", 32'(bus.inst_is_compressed), 32'd0);
        tick();
        check_eq("st_tail_inst", bus.inst_out, 32'h0000_4581);
        check_eq("st_tail_pc", bus.inst_pc_out, 32'h0000_0206);
        tick();
        check_eq("st_next_pc", bus.fetch_pc, 32'h0000_0208);
        check_eq("st_mis2", 32'(bus.misalign_fetch), 32'd0);
`endif

        // Asynchronous reset while an instruction is presented
        bus.inst_out_ready = 1'b0;
        fetch_word(32'h0040_0093);
        check_eq("pre_rst_inst", bus.inst_out, 32'h0040_0093);
        reset = 1'b0;
        #1;
        check_eq("arst_no_out", 32'(bus.inst_out_valid), 32'd0);
        check_eq("arst_inst", bus.inst_out, 32'd0);
        check_eq("arst_no_req", 32'(bus.fetch_req), 32'd0);
        tick();
        reset = 1'b1;
        bus.inst_out_ready = 1'b1;
        tick();
        check_eq("reboot_req", 32'(bus.fetch_req), 32'd1);
        check_eq("reboot_pc", bus.fetch_pc, 32'h0000_0100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
